// File: rtl/la_clkgate_pkg.sv
// State encoding shared by the clock-gating controller and its users.
package la_clkgate_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/la_clkgate_ctrl_if.sv
// Request/acknowledge bundle between the gated-domain requesters and the controller.
interface la_clkgate_ctrl_if #(
  parameter int N = 4
);

  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic         busy;

  modport master (output req, output busy, input ack);
  modport slave  (input req, input busy, output ack);

endinterface

// File: rtl/la_clkgate_timer.sv
// Loadable down-counter; holds at zero and flags done there.
module la_clkgate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         done
);

  assign done = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !done) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/la_clkgate_ctrl.sv
// Clock-gating controller: sequences en/ack for a shared gated clock domain.
// Optional macro LA_CLKGATE_CTRL_STATS_EN adds the gated_cnt statistics output.
//
// state | meaning
// OFF   | clock gated, waiting for demand
// WAKE  | en asserted, letting the gated clock settle before granting
// ON    | clock running, acks follow requests, idle time is tracked
// DRAIN | one cycle with acks withdrawn before gating
module la_clkgate_ctrl
  import la_clkgate_pkg::*;
#(
  parameter int    N    = 4,
  parameter int    IW   = 8,
  parameter int    WAKE = 2,
  parameter string PROP = "DEFAULT"
) (
  input  logic                clk,
  input  logic                nreset,
  la_clkgate_ctrl_if.slave    bus,
  input  logic [IW-1:0]       cfg_idle,
  input  logic                cfg_bypass,
  output logic                en,
  output logic [STATE_W-1:0]  state
`ifdef LA_CLKGATE_CTRL_STATS_EN
  ,
  output logic [31:0]         gated_cnt
`endif
);

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE - 1);

  state_t        state_q, state_d;
  logic          demand;
  logic          en_q;
  logic [N-1:0]  ack_q, ack_d;
  logic          wake_load, wake_dec, wake_done;
  logic [3:0]    wake_cnt;
  logic          idle_load, idle_dec, idle_done;
  logic [IW-1:0] idle_rem, idle_cnt, idle_next;

  assign demand = (|bus.req) | bus.busy;

  // Idle timer runs down from all-ones, so elapsed idle time is its complement
  // and reaching zero is saturation.
  assign idle_cnt  = ~idle_rem;
  assign idle_next = idle_done ? idle_cnt : idle_cnt + 1'b1;
  assign idle_load = (state_q != ON) || demand;
  assign idle_dec  = !idle_load;

  la_clkgate_timer #(.W(4)) u_wake_tmr (
    .clk      (clk),
    .nreset   (nreset),
    .load     (wake_load),
    .load_val (WAKE_LOAD),
    .dec      (wake_dec),
    .cnt      (wake_cnt),
    .done     (wake_done)
  );

  la_clkgate_timer #(.W(IW)) u_idle_tmr (
    .clk      (clk),
    .nreset   (nreset),
    .load     (idle_load),
    .load_val ({IW{1'b1}}),
    .dec      (idle_dec),
    .cnt      (idle_rem),
    .done     (idle_done)
  );

  // The WAKE parameter shadows the imported state name, hence the qualified form.
  always_comb begin
    state_d   = state_q;
    wake_load = 1'b0;
    wake_dec  = 1'b0;
    case (state_q)
      OFF: begin
        wake_load = 1'b1;
        if (demand) state_d = la_clkgate_pkg::WAKE;
      end
      la_clkgate_pkg::WAKE: begin
        if (wake_done) state_d = ON;
        else           wake_dec = |wake_cnt;
      end
      ON: begin
        if (!demand && (cfg_idle != '0) && (idle_next >= cfg_idle)) state_d = DRAIN;
      end
      DRAIN: state_d = demand ? ON : OFF;
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    ack_d = '0;
    if (cfg_bypass || (state_q == ON && state_d == ON)) ack_d = bus.req;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= OFF;
      en_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d != OFF);
      ack_q   <= ack_d;
    end
  end

  assign en      = en_q | cfg_bypass;
  assign bus.ack = (cfg_bypass || state_q == ON) ? ack_q : '0;
  assign state   = state_q;

`ifdef LA_CLKGATE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!nreset)             gated_cnt <= '0;
    else if (state_q == OFF) gated_cnt <= gated_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// Directed + randomized bench for la_clkgate_ctrl against a cycle-level reference model.
module tb_la_clkgate_ctrl;

  localparam int WAKE_CYC = 2;
  localparam int IDLE_MAX = 255;

  logic       clk;
  logic       nreset;
  logic [7:0] cfg_idle;
  logic       cfg_bypass;
  logic       en;
  logic [1:0] state;
`ifdef LA_CLKGATE_CTRL_STATS_EN
  logic [31:0] gated_cnt;
`endif

  la_clkgate_ctrl_if #(.N(4)) bus ();

  la_clkgate_ctrl #(.N(4), .IW(8), .WAKE(WAKE_CYC), .PROP("DEFAULT")) dut (
    .clk        (clk),
    .nreset     (nreset),
    .bus        (bus),
    .cfg_idle   (cfg_idle),
    .cfg_bypass (cfg_bypass),
    .en         (en),
    .state      (state)
`ifdef LA_CLKGATE_CTRL_STATS_EN
    ,
    .gated_cnt  (gated_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // reference model: phase 0..3, cycles spent waking, idle cycles seen in ON
  int          m_st = 0;
  int          m_wait = 0;
  int          m_idle = 0;
  bit          m_en = 1'b0;
  logic [3:0]  m_ack = '0;
  logic [31:0] m_gated = '0;
  logic        cur_byp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic b, input logic [7:0] ci,
                            input logic byp, input logic nr);
    int ns;
    bit dem;
    if (!nr) begin
      m_st = 0; m_wait = 0; m_idle = 0; m_en = 1'b0; m_ack = '0; m_gated = '0;
      return;
    end
    if (m_st == 0) m_gated = m_gated + 32'd1;
    dem = (r != 4'd0) || b;
    ns  = m_st;
    case (m_st)
      0: if (dem) begin ns = 1; m_wait = 0; end
      1: begin m_wait++; if (m_wait >= WAKE_CYC) ns = 2; end
      2: begin
        if (dem) m_idle = 0;
        else begin
          if (m_idle < IDLE_MAX) m_idle++;
          if (ci != 8'd0 && m_idle >= int'(ci)) ns = 3;
        end
      end
      default: ns = dem ? 2 : 0;
    endcase
    if (ns == 2 && m_st != 2) m_idle = 0;
    m_ack = byp ? r : ((m_st == 2 && ns == 2) ? r : 4'd0);
    m_en  = (ns != 0);
    m_st  = ns;
  endtask

  task automatic drive(input logic [3:0] r, input logic b, input logic [7:0] ci,
                       input logic byp, input logic nr);
    bus.req = r; bus.busy = b; cfg_idle = ci; cfg_bypass = byp; nreset = nr;
    cur_byp = byp;
  endtask

  task automatic settle();
    @(posedge clk);
    model_step(bus.req, bus.busy, cfg_idle, cfg_bypass, nreset);
    @(negedge clk);
    check("state", 32'(state), 32'(m_st));
    check("en", 32'(en), 32'(m_en | cur_byp));
    check("ack", 32'(bus.ack), (cur_byp || m_st == 2) ? 32'(m_ack) : 32'd0);
`ifdef LA_CLKGATE_CTRL_STATS_EN
    check("gated_cnt", gated_cnt, m_gated);
`endif
  endtask

  task automatic cyc(input logic [3:0] r, input logic b, input logic [7:0] ci,
                     input logic byp, input logic nr);
    drive(r, b, ci, byp, nr);
    settle();
  endtask

  int cfg_tab[7] = '{0, 1, 2, 3, 4, 6, 9};

  initial begin
    logic [3:0] r;
    logic       b;
    logic [7:0] ci;
    logic       byp;
    logic       nr;
    int         level;

    drive(4'd0, 1'b0, 8'd3, 1'b0, 1'b0);

    // reset
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);

    // wake then grant
    cyc(4'b0001, 1'b0, 8'd3, 1'b0, 1'b1);
    check("wake_en", 32'(en), 32'd1);
    check("wake_st1", 32'(state), 32'd1);
    cyc(4'b0001, 1'b0, 8'd3, 1'b0, 1'b1);
    check("wake_st2", 32'(state), 32'd1);
    cyc(4'b0001, 1'b0, 8'd3, 1'b0, 1'b1);
    check("on_entry", 32'(state), 32'd2);
    check("on_ack0", 32'(bus.ack), 32'd0);
    cyc(4'b0001, 1'b0, 8'd3, 1'b0, 1'b1);
    check("on_ack1", 32'(bus.ack), 32'd1);

    // idle threshold 3 -> DRAIN -> OFF
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("idle2_on", 32'(state), 32'd2);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("drain_st", 32'(state), 32'd3);
    check("drain_en", 32'(en), 32'd1);
    check("drain_ack", 32'(bus.ack), 32'd0);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("off_st", 32'(state), 32'd0);
    check("off_en", 32'(en), 32'd0);

    // demand arriving in the threshold cycle wins
    repeat (3) cyc(4'b0001, 1'b0, 8'd3, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 8'd3, 1'b0, 1'b1);
    check("coll_st", 32'(state), 32'd2);
    check("coll_ack", 32'(bus.ack), 32'd4);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("coll_clr_on", 32'(state), 32'd2);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("coll_drain", 32'(state), 32'd3);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);

    // cfg_idle=0 never gates; live change then takes effect
    repeat (3) cyc(4'b0010, 1'b0, 8'd0, 1'b0, 1'b1);
    repeat (1000) cyc(4'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("noidle_st", 32'(state), 32'd2);
    check("noidle_en", 32'(en), 32'd1);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("live_cfg_drain", 32'(state), 32'd3);
    cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("live_cfg_off", 32'(state), 32'd0);

    // bypass from OFF
    drive(4'b1000, 1'b0, 8'd3, 1'b1, 1'b1);
    #1;
    check("byp_en_comb", 32'(en), 32'd1);
    check("byp_st_off", 32'(state), 32'd0);
    settle();
    check("byp_ack", 32'(bus.ack), 32'd8);
    repeat (10) cyc(4'd0, 1'b0, 8'd3, 1'b0, 1'b1);
    check("byp_back_off", 32'(state), 32'd0);

    // reset while ON with ack=0011
    repeat (4) cyc(4'b0011, 1'b0, 8'd3, 1'b0, 1'b1);
    check("pre_rst_ack", 32'(bus.ack), 32'd3);
    cyc(4'b0011, 1'b0, 8'd3, 1'b0, 1'b0);
    check("mid_rst_st", 32'(state), 32'd0);
    check("mid_rst_en", 32'(en), 32'd0);
    check("mid_rst_ack", 32'(bus.ack), 32'd0);
`ifdef LA_CLKGATE_CTRL_STATS_EN
    check("mid_rst_gated", gated_cnt, 32'd0);
`endif
    cyc(4'b0011, 1'b0, 8'd3, 1'b0, 1'b1);
    check("post_rst_wake", 32'(state), 32'd1);

    // randomized traffic
    level = 50;
    ci = 8'd3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 32 == 0) level = $urandom_range(0, 100);
      r   = ($urandom_range(0, 99) < level) ? 4'($urandom) : 4'd0;
      b   = ($urandom_range(0, 399) < level);
      if ($urandom_range(0, 63) == 0) ci = 8'(cfg_tab[$urandom_range(0, 6)]);
      byp = ($urandom_range(0, 49) == 0);
      nr  = ($urandom_range(0, 299) != 0);
      cyc(r, b, ci, byp, nr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/la_clkgate_ctrl.md
LA_CLKGATE_CTRL -- requirements
Module: la_clkgate_ctrl

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the gated clock domain.
REQ-002 Parameter IW, default 8: width of the idle-threshold counter.
REQ-003 Parameter WAKE, default 2: cycles en is held high before grant, range 1..15.
REQ-004 Parameter PROP, default "DEFAULT": implementation property string, passed through unused.
REQ-005 clk  input  1: single clock; all state is updated on its rising edge.
REQ-006 nreset  input  1: reset, synchronous and active-low.
REQ-007 req  input  N: per-requester demand for the gated clock; held high until ack.
REQ-008 busy  input  1: activity flag from the gated domain; counts as demand.
REQ-009 cfg_idle  input  IW: idle cycles before gating; 0 means never gate.
REQ-010 cfg_bypass  input  1: forces the clock enabled.
REQ-011 en  output  1: enable to the integrated clock-gating cell.
REQ-012 ack  output  N: per-requester grant, meaning the clock is running.
REQ-013 state  output  2: current FSM state, for debug.

Function
REQ-014 FSM states: OFF=0, WAKE=1, ON=2, DRAIN=3.
REQ-015 OFF: en=0; if any req bit or busy is high, go to WAKE next cycle.
REQ-016 WAKE: en=1; the timer counts WAKE cycles, then the FSM goes to ON; req dropping during WAKE does not abort.
REQ-017 ON: en=1; ack[i] is set the cycle after req[i] is sampled high and cleared the cycle after req[i] is sampled low.
REQ-018 ON idle counting: the idle counter increments each cycle req==0 and busy==0, clears on any demand, and saturates at 2^IW-1.
REQ-019 ON to DRAIN when the idle count is >= cfg_idle and cfg_idle!=0; the comparison uses the live cfg_idle value.
REQ-020 DRAIN: en=1 and ack=0 for exactly one cycle, then go to OFF; demand during DRAIN goes to ON instead, with the idle counter cleared.
REQ-021 If demand arrives in the same cycle the threshold is reached, demand wins: stay in ON and clear the counter.
REQ-022 en is registered and changes only on FSM transitions, with no combinational path from req or busy to en.
REQ-023 cfg_bypass=1: en=1 combinationally and ack follows req with 1-cycle latency in every state; the FSM continues to run.
REQ-024 ack is never high while the FSM is in OFF, WAKE or DRAIN, unless cfg_bypass=1.

Reset
REQ-025 When nreset=0 at a clock edge: state=OFF, en=0, ack=0, idle and wake timers=0.
REQ-026 Reset mid-WAKE or mid-ON takes effect at the next edge; after reset release, pending req restarts at OFF to WAKE.

Configuration
REQ-027 Macro LA_CLKGATE_CTRL_STATS_EN, when defined: adds output gated_cnt [31:0], which counts cycles with state==OFF, wraps at 2^32, and resets to 0.
REQ-028 When LA_CLKGATE_CTRL_STATS_EN is undefined: the port and counter are absent and all other behaviour is identical.

Structure
REQ-029 Package la_clkgate_pkg holds the state encoding constants (OFF, WAKE, ON, DRAIN) and the state width.
REQ-030 Sub-module la_clkgate_timer: a loadable down-counter with a done flag, instantiated twice (wake delay and idle threshold).
REQ-031 The block instantiates no clock-gating cell; en drives an external la_clkicg-family cell.

Verification
REQ-032 Reset, then req=4'b0001 held: en=1 one cycle later, state WAKE for 2 cycles, ack=4'b0001 one cycle after entering ON.
REQ-033 cfg_idle=3, all req and busy low while in ON: DRAIN after 3 idle cycles, OFF one cycle later, en=0.
REQ-034 cfg_idle=3, req[2] rises in the exact threshold cycle: state stays ON, the counter clears, ack[2] follows.
REQ-035 cfg_idle=0, idle for 1000 cycles: state remains ON and en remains 1.
REQ-036 State OFF, cfg_bypass=1, req=4'b1000: en=1 the same cycle, ack=4'b1000 the next cycle.
REQ-037 nreset low for 1 cycle while in ON with ack=4'b0011: next cycle state=OFF, en=0, ack=0; with STATS_EN defined, gated_cnt=0.
